// File: rtl/nn_fixed_pkg.sv
// Shared Q7.8 fixed-point definitions for the neuron datapath.
// Round-and-saturate lives here so every stage agrees on it.
package nn_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC   = 8;
  localparam int RS_W   = 64;

  localparam logic [DATA_W-1:0] Q_ONE = 16'h0100;
  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ROUND,
    ST_DONE
  } mac_state_t;

  localparam logic signed [RS_W-1:0] HALF =
    RS_W'(1) << (FRAC - 1);
  localparam logic signed [RS_W-1:0] R_HI =
    (RS_W'(1) << (DATA_W - 1)) - RS_W'(1);
  localparam logic signed [RS_W-1:0] R_LO =
    -R_HI - RS_W'(1);

  // Input carries 2*FRAC fraction bits; result is Q7.8.
  function automatic logic [DATA_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc
  );
    logic signed [RS_W-1:0] r;
    r = (acc + HALF) >>> FRAC;
    if (r > R_HI)
      return Q_MAX;
    else if (r < R_LO)
      return Q_MIN;
    else
      return DATA_W'(r);
  endfunction

endpackage

// File: rtl/q78_round_sat.sv
// Accumulator to Q7.8 conversion: round half up, then clamp.
// Output format is consumed directly by the sigmoid stage.
module q78_round_sat
  import nn_fixed_pkg::*;
#(
  parameter int ACC_W = 36
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] q
);

  logic signed [RS_W-1:0] acc_x;

  assign acc_x = {{(RS_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign q     = round_sat(acc_x);

endmodule

// File: rtl/neuron_mac.sv
// Neuron pre-activation: bias plus streamed x*w products,
// rounded and saturated to Q7.8 with a done pulse.
module neuron_mac
  import nn_fixed_pkg::*;
#(
  parameter int N_INPUTS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bias_in,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              x_ready,
  output logic              busy,
  output logic [DATA_W-1:0] sum_out,
  output logic              done
);

  localparam int CNT_W =
    (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int ACC_W =
    2*DATA_W + $clog2(N_INPUTS+1) + 1;
  localparam int PW = 2*DATA_W;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_INPUTS - 1);

  mac_state_t             state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]       count;
  logic signed [PW-1:0]   prod;
  logic [DATA_W-1:0]      rnd;
  logic                   xfer;

  assign prod = $signed(x_in) * $signed(w_in);
  assign xfer = x_valid & x_ready;

  q78_round_sat #(
    .ACC_W (ACC_W)
  ) u_rs (
    .acc (acc),
    .q   (rnd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      acc     <= '0;
      count   <= '0;
      x_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Bias is aligned to the product's Q14.16 scale.
            acc <= {{(ACC_W-DATA_W-FRAC){bias_in[DATA_W-1]}},
                    bias_in, {FRAC{1'b0}}};
            count   <= '0;
            busy    <= 1'b1;
            x_ready <= 1'b1;
            state   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            acc <= acc +
              {{(ACC_W-PW){prod[PW-1]}}, prod};
            count <= count + 1'b1;
            if (count == LAST) begin
              x_ready <= 1'b0;
              state   <= ST_ROUND;
            end
          end
        end
        ST_ROUND: begin
          sum_out <= rnd;
          done    <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: vector table plus
// handshake, start-ignore and reset-abort sequences.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bias_in = '0;
  logic        x_valid = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] w_in = '0;
  logic        x_ready;
  logic        busy;
  logic [15:0] sum_out;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_mac #(
    .N_INPUTS (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bias_in (bias_in),
    .x_valid (x_valid),
    .x_in    (x_in),
    .w_in    (w_in),
    .x_ready (x_ready),
    .busy    (busy),
    .sum_out (sum_out),
    .done    (done)
  );

  typedef struct {
    string            name;
    logic [15:0]      bias;
    logic [3:0][15:0] xs;
    logic [3:0][15:0] ws;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic run_eval(
    input  vec_t        v,
    input  logic [7:0]  vpat,
    input  int          vlen,
    input  bit          mid_start,
    output int          last_cyc,
    output int          done_cyc,
    output logic [15:0] res,
    output int          nx
  );
    int idx;
    int p;
    int cyc;
    bit xf;
    idx = 0;
    p = 0;
    last_cyc = -1;
    done_cyc = -1;
    res = '0;
    start = 1'b1;
    bias_in = v.bias;
    @(posedge clk); #1;
    start = 1'b0;
    bias_in = 16'hDEAD;
    cyc = 1;
    while (cyc < 40 && done_cyc < 0) begin
      if (idx < 4) begin
        x_valid = (p < vlen) ? vpat[p] : 1'b1;
        x_in = v.xs[idx];
        w_in = v.ws[idx];
      end else begin
        // Junk offered after the last pair must be refused.
        x_valid = 1'b1;
        x_in = 16'h7FFF;
        w_in = 16'h7FFF;
      end
      start = mid_start && (p == 1);
      xf = x_valid && x_ready;
      p++;
      @(posedge clk); #1;
      cyc++;
      if (xf) begin
        idx++;
        if (idx == 4) last_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        res = sum_out;
      end
    end
    x_valid = 1'b0;
    start = 1'b0;
    nx = idx;
  endtask

  initial begin
    int lc;
    int dc;
    int nx;
    logic [15:0] res;
    bit saw_done;
    bit saw_rdy;

    tbl[0] = '{"unit", 16'h0000,
      {4{16'h0100}}, {4{16'h0080}}, 16'h0200};
    tbl[1] = '{"neg", 16'h0080,
      {4{16'h0100}}, {4{16'hFF00}}, 16'hFC80};
    tbl[2] = '{"satpos", 16'h0000,
      {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF};
    tbl[3] = '{"satneg", 16'h0000,
      {4{16'h7FFF}}, {4{16'h8000}}, 16'h8000};
    tbl[4] = '{"rnd_up", 16'h0000,
      {16'h0, 16'h0, 16'h0, 16'h0001},
      {16'h0, 16'h0, 16'h0, 16'h0080}, 16'h0001};
    tbl[5] = '{"rnd_neg", 16'h0000,
      {16'h0, 16'h0, 16'h0, 16'h0001},
      {16'h0, 16'h0, 16'h0, 16'hFF80}, 16'h0000};
    tbl[6] = '{"mixed", 16'h0100,
      {16'h0040, 16'hFF00, 16'h0180, 16'h0200},
      {16'hFF00, 16'h0300, 16'h0200, 16'h0100},
      16'h02C0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_ready", x_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;

    x_valid = 1'b1;
    x_in = 16'h1234;
    w_in = 16'h5678;
    @(posedge clk); #1;
    chk("idle_x_ready", x_ready, 0);
    chk("idle_busy", busy, 0);
    x_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_eval(tbl[i], 8'hFF, 0, 1'b0,
               lc, dc, res, nx);
      chk({tbl[i].name, "_sum"}, res, tbl[i].exp);
      chk({tbl[i].name, "_lat"}, dc, 6);
      chk({tbl[i].name, "_nx"}, nx, 4);
      @(posedge clk); #1;
      chk({tbl[i].name, "_pulse"}, done, 0);
      chk({tbl[i].name, "_held"}, sum_out,
          tbl[i].exp);
    end

    run_eval(tbl[6], 8'b0101_1001, 7, 1'b1,
             lc, dc, res, nx);
    chk("tog_sum", res, 16'h02C0);
    chk("tog_nx", nx, 4);
    chk("tog_last", lc, 8);
    chk("tog_done", dc, lc + 1);
    @(posedge clk); #1;
    chk("tog_pulse", done, 0);
    chk("tog_no_queue", busy, 0);

    start = 1'b1;
    bias_in = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0;
    x_valid = 1'b1;
    x_in = 16'h0100;
    w_in = 16'h0080;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_x_ready", x_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum_out, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    saw_done = 1'b0;
    saw_rdy = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      if (x_ready) saw_rdy = 1'b1;
    end
    x_valid = 1'b0;
    chk("abort_no_done", saw_done, 0);
    chk("abort_no_ready", saw_rdy, 0);
    chk("abort_sum_hold", sum_out, 16'h0000);

    run_eval(tbl[1], 8'hFF, 0, 1'b0,
             lc, dc, res, nx);
    chk("post_rst_sum", res, 16'hFC80);
    chk("post_rst_lat", dc, 6);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
